core_dispatch_scheduler: RTL
============================

Name: core_dispatch_scheduler

Overview:
- Sequences a bank of CORE_NUMBER validator cores over a point cloud: loads the first points into the cores, then dispatches each next point index to whichever core finishes.
- Arbitrates between cores finishing in the same cycle with a round-robin grant, so exactly one result is retired per cycle.
- Serialises outlier point positions into the downstream outlier FIFO under full backpressure, and flags completion once every core has drained.
- Sits between the point cache/feeder and the cores, replacing ad-hoc per-cycle scanning with a registered, one-grant-per-cycle scheduler.

Parameters:
- N, 16, base data width; point indices and counters are 2*N bits.
- CORE_NUMBER, 16, number of validator cores scheduled (power of two, >=2).
- CW, $clog2(CORE_NUMBER), core index width (derived localparam).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- pause  in  1  while 1, no grants and no loads occur; all state is held.
- point_cloud_size  in  2N  number of points; sampled on start.
- core_done  in  CORE_NUMBER  per-core level: the core has a result (inlier or outlier).
- core_outlier  in  CORE_NUMBER  per-core result flag; valid when core_done is 1.
- core_load  out  CORE_NUMBER  one-hot, one-cycle pulse that resets/loads the core.
- load_index  out  2N  point index for the core pulsed in core_load; valid only with that pulse.
- fifo_full  in  1  outlier FIFO full.
- fifo_wr_en  out  1  outlier FIFO push.
- fifo_din  out  2N  outlier point position.
- outlier_count  out  2N  outliers pushed this run.
- busy  out  1  1 in INIT, RUN or DRAIN.
- done  out  1  run complete; held until the next start or reset.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State IDLE.
  - All outputs 0: core_load, load_index, fifo_wr_en, fifo_din, outlier_count, busy, done.
  - Internal registers cleared: active[], holdoff[], pos_buf[], next_pos, rr_ptr.
- Reset asserted mid-run aborts the run immediately; no FIFO push completes after reset.
- All outputs are registered. Latency from a granted core_done to its core_load and fifo_wr_en is 1 cycle.
- States:
  - IDLE: on start, latch size, clear outlier_count and next_pos, deassert done. If size==0 go to DONE, else go to INIT.
  - INIT: each non-paused cycle, load core k=next_pos:
    - pulse core_load[k], load_index=next_pos, pos_buf[k]=next_pos;
    - set active[k] and holdoff[k]; next_pos++.
    - Go to RUN when next_pos reaches min(CORE_NUMBER, size).
    - size < CORE_NUMBER leaves the upper cores inactive for the whole run.
  - RUN / DRAIN, once per non-paused cycle:
    - Candidates are core_done & active & ~holdoff.
    - Grant the first candidate at or after rr_ptr (wrapping); then rr_ptr = grant+1 mod CORE_NUMBER.
    - If the granted core has core_outlier=1:
      - fifo_full=1: stall with no grant; rr_ptr unchanged.
      - otherwise: fifo_wr_en=1, fifo_din=pos_buf[g], outlier_count++.
    - Then:
      - if next_pos < size: core_load[g] pulse, load_index=next_pos, pos_buf[g]=next_pos, set holdoff[g], next_pos++;
      - else clear active[g].
    - RUN goes to DRAIN when next_pos==size.
    - DRAIN goes to DONE when active==0; done=1 in the same cycle the state is entered.
  - DONE: done=1, busy=0; start begins a new run (treated as from IDLE).
- Holdoff: holdoff[k] clears one cycle after core_load[k]. This masks the stale core_done of a core that is still resetting.
- Inlier grants never stall on fifo_full. Only an outlier at the head of the round-robin order stalls, which preserves fairness.
- Simultaneous finishes: one grant per cycle; the others wait, with core_done held by the core.
- start while busy is ignored. pause=1 with start=1 in IDLE: the start is latched and INIT waits until pause=0.
- next_pos, outlier_count, pos_buf[] and size are 2N bits, unsigned; next_pos never exceeds size.

Decomposition:
- Package dror_sched_pkg:
  - state enum (IDLE, INIT, RUN, DRAIN, DONE);
  - width helper localparams (IDX_W = 2*N).
- Sub-module rr_arbiter:
  - parameter CORE_NUMBER;
  - inputs req[CORE_NUMBER], ptr[CW];
  - outputs gnt_valid, gnt_idx[CW];
  - purely combinational rotate / priority-encode / unrotate. It is reused by the cache-refill path.

Test Plan (CORE_NUMBER=4, N=16):
- Basic run: size=10; each core asserts core_done 3 cycles after load, no outliers. Required: 10 core_load pulses with load_index 0..9; done exactly once; outlier_count=0.
- Outlier ordering: size=6; cores 1 and 3 finish together with outlier=1. Required: two pushes on consecutive cycles; fifo_din=1 then 3 (rr_ptr=0); outlier_count=2.
- Backpressure: fifo_full=1 for 5 cycles with the head core an outlier. Required: no core_load and no fifo_wr_en during those cycles; the push occurs 1 cycle after fifo_full drops; no index lost or duplicated.
- Small cloud: size=2. Required: only cores 0 and 1 loaded; DRAIN after both finish; done=1; core_load[3:2] never pulses. Also size=0: done=1 one cycle after start, no loads.
- Pause and holdoff: pause=1 for 4 cycles mid-RUN with core_done high. Required: no grants while paused. Separately, hold core_done stuck high through a load. Required: the core is not re-granted in the cycle immediately after its core_load.
- Reset mid-run: drop reset_n in DRAIN. Required: all outputs 0 asynchronously. Then start with size=5 completes normally with load_index 0..4.

Source files
------------

// File: rtl/dror_sched_pkg.sv
// Shared types and width helpers for the core dispatch scheduler.
//   sched_state_e : scheduler FSM states
//   idx_width()   : point index / counter width for a given base width N
package dror_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRun,
    StDrain,
    StDone
  } sched_state_e;

  localparam int unsigned DefaultN = 16;
  localparam int unsigned IDX_W    = 2 * DefaultN;

  // Point indices, sizes and counters are twice the base data width.
  function automatic int unsigned idx_width(int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i       : request vector, one bit per requester
//   ptr_i       : index with highest priority this cycle
//   gnt_valid_o : at least one request is set
//   gnt_idx_o   : first set request at or after ptr_i, wrapping
// Requester count must be a power of two so index arithmetic wraps naturally.
module rr_arbiter #(
  parameter int unsigned CORE_NUMBER = 16,
  localparam int unsigned CW = $clog2(CORE_NUMBER)
) (
  input  logic [CORE_NUMBER-1:0] req_i,
  input  logic [CW-1:0]          ptr_i,
  output logic                   gnt_valid_o,
  output logic [CW-1:0]          gnt_idx_o
);

  logic [CORE_NUMBER-1:0] rot;
  logic [CW-1:0]          enc;

  // Rotate so that ptr_i lands on bit 0.
  always_comb begin
    rot = '0;
    for (int i = 0; i < CORE_NUMBER; i++) begin
      rot[i] = req_i[ptr_i + CW'(i)];
    end
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    enc         = '0;
    gnt_valid_o = 1'b0;
    for (int i = CORE_NUMBER - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc         = CW'(i);
        gnt_valid_o = 1'b1;
      end
    end
  end

  // Undo the rotation.
  assign gnt_idx_o = enc + ptr_i;

endmodule

// File: rtl/core_dispatch_scheduler.sv
// Dispatch scheduler for a bank of validator cores.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i, pause_i       : run start pulse (IDLE/DONE only), global hold
//   point_cloud_size_i     : number of points, sampled on start
//   core_done_i            : per-core result-ready level
//   core_outlier_i         : per-core outlier flag, valid with core_done_i
//   core_load_o            : one-hot load pulse for the selected core
//   load_index_o           : point index accompanying core_load_o
//   fifo_full_i            : outlier FIFO full
//   fifo_wr_en_o, fifo_din_o : outlier FIFO push and point position
//   outlier_count_o        : outliers pushed this run
//   busy_o, done_o         : run in progress, run complete (held)
// Loads the first points into the cores, then hands each next point to a core
// that finishes, retiring at most one result per cycle in round-robin order.
module core_dispatch_scheduler
  import dror_sched_pkg::*;
#(
  parameter int unsigned N           = 16,
  parameter int unsigned CORE_NUMBER = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   pause_i,
  input  logic [2*N-1:0]         point_cloud_size_i,
  input  logic [CORE_NUMBER-1:0] core_done_i,
  input  logic [CORE_NUMBER-1:0] core_outlier_i,
  output logic [CORE_NUMBER-1:0] core_load_o,
  output logic [2*N-1:0]         load_index_o,
  input  logic                   fifo_full_i,
  output logic                   fifo_wr_en_o,
  output logic [2*N-1:0]         fifo_din_o,
  output logic [2*N-1:0]         outlier_count_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned CW   = $clog2(CORE_NUMBER);
  localparam int unsigned IdxW = idx_width(N);

  localparam logic [IdxW-1:0] IdxOne     = IdxW'(1);
  localparam logic [IdxW-1:0] CoreNumIdx = IdxW'(CORE_NUMBER);

  sched_state_e state_q, state_d;

  logic [IdxW-1:0]        size_q, size_d;
  logic [IdxW-1:0]        next_pos_q, next_pos_d;
  logic [IdxW-1:0]        outlier_count_q, outlier_count_d;
  logic [CORE_NUMBER-1:0] active_q, active_d;
  logic [CORE_NUMBER-1:0] holdoff_q, holdoff_d;
  logic [IdxW-1:0]        pos_buf_q [CORE_NUMBER];
  logic [IdxW-1:0]        pos_buf_d [CORE_NUMBER];
  logic [CW-1:0]          rr_ptr_q, rr_ptr_d;

  logic [CORE_NUMBER-1:0] core_load_q, core_load_d;
  logic [IdxW-1:0]        load_index_q, load_index_d;
  logic                   fifo_wr_en_q, fifo_wr_en_d;
  logic [IdxW-1:0]        fifo_din_q, fifo_din_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [CORE_NUMBER-1:0] cand;
  logic                   gnt_valid;
  logic [CW-1:0]          gnt_idx;
  logic                   stall;
  logic [CW-1:0]          slot;
  logic [IdxW-1:0]        init_limit;

  // A core in holdoff was just loaded; its core_done may still be stale.
  assign cand       = core_done_i & active_q & ~holdoff_q;
  assign stall      = core_outlier_i[gnt_idx] & fifo_full_i;
  assign slot       = next_pos_q[CW-1:0];
  assign init_limit = (size_q < CoreNumIdx) ? size_q : CoreNumIdx;

  rr_arbiter #(
    .CORE_NUMBER(CORE_NUMBER)
  ) u_rr_arbiter (
    .req_i      (cand),
    .ptr_i      (rr_ptr_q),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx)
  );

  always_comb begin
    state_d         = state_q;
    size_d          = size_q;
    next_pos_d      = next_pos_q;
    outlier_count_d = outlier_count_q;
    active_d        = active_q;
    // Holdoff lasts exactly the cycle the load pulse is visible, pause or not.
    holdoff_d       = holdoff_q & ~core_load_q;
    pos_buf_d       = pos_buf_q;
    rr_ptr_d        = rr_ptr_q;
    core_load_d     = '0;
    load_index_d    = load_index_q;
    fifo_wr_en_d    = 1'b0;
    fifo_din_d      = fifo_din_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          size_d          = point_cloud_size_i;
          next_pos_d      = '0;
          outlier_count_d = '0;
          state_d         = (point_cloud_size_i == '0) ? StDone : StInit;
        end
      end

      StInit: begin
        if (!pause_i) begin
          core_load_d[slot] = 1'b1;
          load_index_d      = next_pos_q;
          pos_buf_d[slot]   = next_pos_q;
          active_d[slot]    = 1'b1;
          holdoff_d[slot]   = 1'b1;
          next_pos_d        = next_pos_q + IdxOne;
          if (next_pos_d == init_limit) begin
            state_d = StRun;
          end
        end
      end

      StRun, StDrain: begin
        // An outlier head blocks everyone behind it, keeping the order fair.
        if (!pause_i && gnt_valid && !stall) begin
          rr_ptr_d = gnt_idx + CW'(1);
          if (core_outlier_i[gnt_idx]) begin
            fifo_wr_en_d    = 1'b1;
            fifo_din_d      = pos_buf_q[gnt_idx];
            outlier_count_d = outlier_count_q + IdxOne;
          end
          if (next_pos_q < size_q) begin
            core_load_d[gnt_idx] = 1'b1;
            load_index_d         = next_pos_q;
            pos_buf_d[gnt_idx]   = next_pos_q;
            holdoff_d[gnt_idx]   = 1'b1;
            next_pos_d           = next_pos_q + IdxOne;
          end else begin
            active_d[gnt_idx] = 1'b0;
          end
        end
        if (!pause_i) begin
          if (state_q == StRun && next_pos_d == size_q) begin
            state_d = StDrain;
          end else if (state_q == StDrain && active_d == '0) begin
            state_d = StDone;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = state_d inside {StInit, StRun, StDrain};
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      size_q          <= '0;
      next_pos_q      <= '0;
      outlier_count_q <= '0;
      active_q        <= '0;
      holdoff_q       <= '0;
      rr_ptr_q        <= '0;
      core_load_q     <= '0;
      load_index_q    <= '0;
      fifo_wr_en_q    <= 1'b0;
      fifo_din_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      for (int k = 0; k < CORE_NUMBER; k++) begin
        pos_buf_q[k] <= '0;
      end
    end else begin
      state_q         <= state_d;
      size_q          <= size_d;
      next_pos_q      <= next_pos_d;
      outlier_count_q <= outlier_count_d;
      active_q        <= active_d;
      holdoff_q       <= holdoff_d;
      rr_ptr_q        <= rr_ptr_d;
      core_load_q     <= core_load_d;
      load_index_q    <= load_index_d;
      fifo_wr_en_q    <= fifo_wr_en_d;
      fifo_din_q      <= fifo_din_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      for (int k = 0; k < CORE_NUMBER; k++) begin
        pos_buf_q[k] <= pos_buf_d[k];
      end
    end
  end

  assign core_load_o     = core_load_q;
  assign load_index_o    = load_index_q;
  assign fifo_wr_en_o    = fifo_wr_en_q;
  assign fifo_din_o      = fifo_din_q;
  assign outlier_count_o = outlier_count_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule
